// File: rtl/div_pkg.sv
// div_pkg: shared width and FSM state encoding for the sequential divider.
package div_pkg;
   localparam int N = 32;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/adder_32.sv
// adder_32: ripple adder; T=1 turns it into a - b with cout as the no-borrow flag.
module adder_32 #(
   parameter int W = 32,
   parameter bit T = 1'b0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] s,
   output logic         cout
);
   logic [W-1:0] bb;
   assign bb = T ? ~b : b;
   assign {cout, s} = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, T};
endmodule

// File: rtl/div_32.sv
// div_32: signed/unsigned restoring divider, one quotient bit per clock.
module div_32 #(
   parameter int N = div_pkg::N
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_signed,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   input  logic         i_flush,
   output logic         o_busy,
   output logic         o_valid,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder,
   output logic         o_div_zero
);
   import div_pkg::state_t;
   import div_pkg::IDLE;
   import div_pkg::CALC;
   import div_pkg::DONE;
   localparam int CW = $clog2(N);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [N-1:0] rem, quo, dvs, q_hold, r_hold, sh_rem, diff, q_fix, r_fix;
   logic q_neg, r_neg, dz, dz_hold, cout, no_borrow, accept, zero_dvs;
   assign accept   = state == IDLE && i_start && !i_flush;
   assign zero_dvs = i_divisor == '0;
   assign sh_rem   = {rem[N-2:0], quo[N-1]};
   adder_32 #(.W(N), .T(1'b1)) u_sub (.a(sh_rem), .b(dvs), .s(diff), .cout(cout));
   // the bit shifted out of rem makes the partial remainder exceed any divisor
   assign no_borrow   = cout | rem[N-1];
   assign q_fix       = q_neg ? -quo : quo;
   assign r_fix       = r_neg ? -rem : rem;
   assign o_busy      = state != IDLE;
   assign o_valid     = state == DONE && !i_flush;
   assign o_quotient  = o_valid ? q_fix : q_hold;
   assign o_remainder = o_valid ? r_fix : r_hold;
   assign o_div_zero  = o_valid ? dz : dz_hold;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else          state <= state_n;
   always_comb begin
      state_n = i_flush                      ? IDLE :
                accept                       ? (zero_dvs ? DONE : CALC) :
                state == CALC && cnt == '0   ? DONE :
                state == DONE                ? IDLE : state;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         dz      <= 1'b0;
         q_hold  <= '0;
         r_hold  <= '0;
         dz_hold <= 1'b0;
      end else if (accept && zero_dvs) begin
         quo   <= '1;
         rem   <= i_dividend;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         dz    <= 1'b1;
         cnt   <= '0;
      end else if (accept) begin
         quo   <= i_signed && i_dividend[N-1] ? -i_dividend : i_dividend;
         dvs   <= i_signed && i_divisor[N-1] ? -i_divisor : i_divisor;
         rem   <= '0;
         q_neg <= i_signed && (i_dividend[N-1] ^ i_divisor[N-1]);
         r_neg <= i_signed && i_dividend[N-1];
         dz    <= 1'b0;
         cnt   <= CW'(N - 1);
      end else if (state == CALC && !i_flush) begin
         rem <= no_borrow ? diff : sh_rem;
         quo <= {quo[N-2:0], no_borrow};
         cnt <= cnt == '0 ? cnt : cnt - CW'(1);
      end else if (o_valid) begin
         q_hold  <= q_fix;
         r_hold  <= r_fix;
         dz_hold <= dz;
      end
   end
endmodule
